// File: rtl/jtdsp16_sio_pkg.sv
// Shared definitions for the DSP16 serial output transmitter.
//   - sio_state_e : transmitter states (IDLE=0, SHIFT=1)
//   - FrameLen16/FrameLen8 : frame lengths in bits
//   - DefHalf0..3 : default ock half-periods in cen ticks, selected by ock_div
//   - max4 : largest of four values, used to size the divider counter
//   - first_bit : first serial bit of a fresh word
package jtdsp16_sio_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } sio_state_e;

    localparam int unsigned FrameLen16 = 16;
    localparam int unsigned FrameLen8  = 8;

    localparam int unsigned DefHalf0 = 2;
    localparam int unsigned DefHalf1 = 6;
    localparam int unsigned DefHalf2 = 8;
    localparam int unsigned DefHalf3 = 10;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // First serial bit of a word for the given frame length and bit order.
    function automatic logic first_bit(input logic [15:0] word, input logic len16,
                                       input logic msb_first);
        if (!msb_first) return word[0];
        return len16 ? word[15] : word[7];
    endfunction

endpackage

// File: rtl/jtdsp16_sio_clkdiv.sv
// Free-running serial clock divider.
// cnt runs 0..2H-1 on cen ticks; ock is high while cnt < H. H is re-selected from
// ock_div only when the counter wraps, so a divider change never truncates a period.
// Ports:
//   clk_i, rst_i (sync, active-high), cen_i : clocking
//   ock_div_i  : selects HALF0..HALF3
//   ock_o      : registered serial clock
//   boundary_o : one-tick pulse on the cen tick where cnt == 2H-1 (ock about to rise)
module jtdsp16_sio_clkdiv
    import jtdsp16_sio_pkg::*;
#(
    parameter int unsigned HALF0 = DefHalf0,
    parameter int unsigned HALF1 = DefHalf1,
    parameter int unsigned HALF2 = DefHalf2,
    parameter int unsigned HALF3 = DefHalf3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cen_i,
    input  logic [1:0] ock_div_i,
    output logic       ock_o,
    output logic       boundary_o
);

    localparam int unsigned CntW = $clog2(2 * max4(HALF0, HALF1, HALF2, HALF3));

    typedef logic [CntW-1:0] cnt_t;

    cnt_t cnt_q, cnt_d;
    cnt_t half_q, half_d;
    cnt_t half_sel;
    cnt_t cnt_last;
    logic ock_q, ock_d;

    always_comb begin
        unique case (ock_div_i)
            2'd0: half_sel = cnt_t'(HALF0);
            2'd1: half_sel = cnt_t'(HALF1);
            2'd2: half_sel = cnt_t'(HALF2);
            2'd3: half_sel = cnt_t'(HALF3);
        endcase
    end

    // 2H-1; modular arithmetic keeps this exact even when 2H hits 2**CntW.
    assign cnt_last   = (half_q << 1) - cnt_t'(1);
    assign boundary_o = cen_i & (cnt_q == cnt_last);

    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        if (boundary_o) begin
            cnt_d  = '0;
            half_d = half_sel;
        end else if (cen_i) begin
            cnt_d = cnt_q + cnt_t'(1);
        end
        ock_d = (cnt_d < half_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            half_q <= half_sel;
            ock_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            ock_q  <= ock_d;
        end
    end

    assign ock_o = ock_q;

endmodule

// File: rtl/jtdsp16_sio_tx.sv
// DSP16 serial output transmitter: obuf -> osr -> ods, with free-running ock and
// a frame-start strobe old. All serial outputs change only on ock rising so the
// receiver can sample on ock falling.
// Optional feature: define JTDSP16_SIO_OVR_EN to enable the sticky overrun flag ovr
// (cleared by clr_ovr); otherwise ovr is tied low and clr_ovr is ignored.
// Ports:
//   clk_i, rst_i (sync, active-high), cen_i : clocking; all state frozen when cen_i=0
//   din_i, wr_i      : obuf write data / strobe
//   len16_i          : 1 = 16-bit frame, 0 = 8-bit frame (din[7:0])
//   msb_first_i      : bit order
//   ock_div_i        : ock half-period select
//   clr_ovr_i        : clear overrun flag
//   ock_o, ods_o     : serial clock / data
//   old_o            : high for the first bit period of each frame
//   obe_o            : output buffer empty
//   ose_o            : shifting active
//   ovr_o            : sticky overrun flag
module jtdsp16_sio_tx
    import jtdsp16_sio_pkg::*;
#(
    parameter int unsigned HALF0 = DefHalf0,
    parameter int unsigned HALF1 = DefHalf1,
    parameter int unsigned HALF2 = DefHalf2,
    parameter int unsigned HALF3 = DefHalf3
) (
    input  logic        rst_i,
    input  logic        clk_i,
    input  logic        cen_i,
    input  logic [15:0] din_i,
    input  logic        wr_i,
    input  logic        len16_i,
    input  logic        msb_first_i,
    input  logic [1:0]  ock_div_i,
    input  logic        clr_ovr_i,
    output logic        ock_o,
    output logic        ods_o,
    output logic        old_o,
    output logic        obe_o,
    output logic        ose_o,
    output logic        ovr_o
);

    logic boundary;

    jtdsp16_sio_clkdiv #(
        .HALF0 (HALF0),
        .HALF1 (HALF1),
        .HALF2 (HALF2),
        .HALF3 (HALF3)
    ) u_clkdiv (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cen_i      (cen_i),
        .ock_div_i  (ock_div_i),
        .ock_o      (ock_o),
        .boundary_o (boundary)
    );

    sio_state_e  state_q, state_d;
    logic [15:0] obuf_q, obuf_d;
    logic [15:0] osr_q, osr_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic        obe_q, obe_d;
    logic        ods_q, ods_d;
    logic        old_q, old_d;
    logic        len16_q, len16_d;
    logic        msb_q, msb_d;
    logic        wr_acc;
    logic        xfer;
    logic        frame_done;
    logic        next_bit;

    assign wr_acc     = wr_i & cen_i;
    assign frame_done = (state_q == StIdle) || (bitcnt_q == 4'd0);

    // Bit that follows osr's current output bit, for the frame's latched settings.
    always_comb begin
        if (!msb_q) next_bit = osr_q[1];
        else        next_bit = len16_q ? osr_q[14] : osr_q[6];
    end

    always_comb begin
        state_d  = state_q;
        obuf_d   = obuf_q;
        osr_d    = osr_q;
        bitcnt_d = bitcnt_q;
        obe_d    = obe_q;
        ods_d    = ods_q;
        old_d    = old_q;
        len16_d  = len16_q;
        msb_d    = msb_q;
        xfer     = 1'b0;

        if (boundary) begin
            if (frame_done) begin
                if (!obe_q) begin
                    // Load from IDLE, or back-to-back reload with no gap bit.
                    xfer     = 1'b1;
                    osr_d    = obuf_q;
                    obe_d    = 1'b1;
                    old_d    = 1'b1;
                    ods_d    = first_bit(obuf_q, len16_i, msb_first_i);
                    bitcnt_d = len16_i ? 4'(FrameLen16 - 1) : 4'(FrameLen8 - 1);
                    len16_d  = len16_i;
                    msb_d    = msb_first_i;
                    state_d  = StShift;
                end else begin
                    ods_d   = 1'b0;
                    old_d   = 1'b0;
                    state_d = StIdle;
                end
            end else begin
                osr_d    = msb_q ? (osr_q << 1) : (osr_q >> 1);
                ods_d    = next_bit;
                old_d    = 1'b0;
                bitcnt_d = bitcnt_q - 4'd1;
            end
        end

        // A write on a transfer tick lands after obuf was consumed, so obe ends at 0.
        if (wr_acc) begin
            obuf_d = din_i;
            obe_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            obuf_q   <= '0;
            osr_q    <= '0;
            bitcnt_q <= '0;
            obe_q    <= 1'b1;
            ods_q    <= 1'b0;
            old_q    <= 1'b0;
            len16_q  <= 1'b0;
            msb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            obuf_q   <= obuf_d;
            osr_q    <= osr_d;
            bitcnt_q <= bitcnt_d;
            obe_q    <= obe_d;
            ods_q    <= ods_d;
            old_q    <= old_d;
            len16_q  <= len16_d;
            msb_q    <= msb_d;
        end
    end

`ifdef JTDSP16_SIO_OVR_EN
    logic ovr_q, ovr_d;

    // Set has priority over clear when both happen on the same tick.
    always_comb begin
        ovr_d = ovr_q;
        if (cen_i && clr_ovr_i) ovr_d = 1'b0;
        if (wr_acc && !obe_q && !xfer) ovr_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ovr_q <= 1'b0;
        else       ovr_q <= ovr_d;
    end

    assign ovr_o = ovr_q;
`else
    logic unused_ovr_inputs;
    assign unused_ovr_inputs = clr_ovr_i ^ xfer;
    assign ovr_o = 1'b0;
`endif

    assign ods_o = ods_q;
    assign old_o = old_q;
    assign obe_o = obe_q;
    assign ose_o = (state_q == StShift);

endmodule
